// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StDrop = 2'd2
  } fetch_state_e;

  localparam logic [31:0] DefaultResetPc = 32'h0000_0000;
  localparam logic [31:0] WordIncr       = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_instr_queue.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs with flush; head is read straight from storage.
module fetch_unit_instr_queue
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  fetch_entry_t             push_entry,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     head_valid,
  output fetch_entry_t             head
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fetch_entry_t    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            do_pop;

  assign do_pop = pop && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared on reset so the head outputs read as zero out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_entry;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign head_valid = (count_q != '0);
  assign head       = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem read at a time, results buffered for the decoder,
// redirects flush the buffer and restart at the new PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DefaultResetPc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  output logic [31:0] fetch_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  fetch_state_e    state_q;
  logic [31:0]     fetch_pc_q, imem_addr_q;
  logic            imem_req_q;

  logic [CntW-1:0] count, count_after;
  logic            push, pop;
  logic [31:0]     next_pc, target_pc;
  fetch_entry_t    push_entry, head;
  logic            head_valid;

  assign push       = (state_q == StReq) && imem_ack && !redirect;
  assign pop        = head_valid && instr_ready && !redirect;
  assign next_pc    = fetch_pc_q + WordIncr;
  assign target_pc  = word_align(redirect_pc);
  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

  // Occupancy after this cycle's push/pop decides whether a back-to-back request is safe.
  always_comb begin
    count_after = count;
    case ({push, pop})
      2'b10:   count_after = count + CntW'(1);
      2'b01:   count_after = count - CntW'(1);
      default: count_after = count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      fetch_pc_q  <= RESET_PC;
      imem_addr_q <= RESET_PC;
      imem_req_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (redirect) begin
            fetch_pc_q <= target_pc;
          end else if (count < DepthCnt) begin
            state_q     <= StReq;
            imem_addr_q <= fetch_pc_q;
            imem_req_q  <= 1'b1;
          end
        end
        StReq: begin
          if (redirect) begin
            fetch_pc_q <= target_pc;
            if (imem_ack) begin
              state_q    <= StIdle;
              imem_req_q <= 1'b0;
            end else begin
              // The old transaction must still complete; its data will be dropped.
              state_q <= StDrop;
            end
          end else if (imem_ack) begin
            fetch_pc_q <= next_pc;
            if (count_after < DepthCnt) begin
              imem_addr_q <= next_pc;
            end else begin
              state_q    <= StIdle;
              imem_req_q <= 1'b0;
            end
          end
        end
        StDrop: begin
          if (redirect) begin
            fetch_pc_q <= target_pc;
          end
          if (imem_ack) begin
            state_q    <= StIdle;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= StIdle;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  fetch_unit_instr_queue #(
    .DEPTH(DEPTH)
  ) u_instr_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .count      (count),
    .head_valid (head_valid),
    .head       (head)
  );

  assign imem_req    = imem_req_q;
  assign imem_addr   = imem_addr_q;
  assign fetch_pc    = fetch_pc_q;
  assign instr_valid = head_valid;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run checked against
// a program-order model (sequential PCs from the last redirect, words from a fixed memory image).
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
  logic [31:0] fetch_pc;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .fetch_pc    (fetch_pc)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          accepted = 0;
  int          lat = 0;
  int          ack_cnt = 0;
  logic        ack_seen = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory responder: acks after `lat` wait cycles of a continuously held request.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset || !imem_req) begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wcnt       = 0;
      end else if (wcnt >= lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
        ack_cnt++;
      end else begin
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        wcnt++;
      end
      ack_seen = imem_ack;
    end
  end

  // One clock of stimulus; the program-order model checks every accepted instruction.
  task automatic cycle(input logic rdy, input logic redir, input logic [31:0] rpc);
    if (prev_req && !ack_seen) begin
      check("req_hold", 32'(imem_req), 32'd1);
      check("addr_hold", imem_addr, prev_addr);
    end
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    if (redir) begin
      exp_pc = {rpc[31:2], 2'b00};
    end else if (instr_valid && rdy) begin
      check("stream_pc", instr_pc, exp_pc);
      check("stream_instr", instr, mem_word(exp_pc));
      exp_pc += 32'd4;
      accepted++;
    end
    prev_req  = imem_req;
    prev_addr = imem_addr;
    @(negedge clk);
    redirect = 1'b0;
  endtask

  task automatic apply_reset();
    #2;
    reset       = 1'b0;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    prev_req    = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", imem_addr, RESET_PC);
    check("rst_fetch_pc", fetch_pc, RESET_PC);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'd0);
    check("rst_instr_pc", instr_pc, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset   = 1'b1;
    exp_pc  = RESET_PC;
    ack_cnt = 0;
  endtask

  initial begin
    int n;
    int a0;

    // Zero-wait memory, decoder always ready.
    apply_reset();
    lat = 0;
    cycle(1'b1, 1'b0, '0);
    check("t1_first_req", 32'(imem_req), 32'd1);
    check("t1_first_addr", imem_addr, RESET_PC);
    cycle(1'b1, 1'b0, '0);
    for (int k = 0; k < 4; k++) begin
      check("t1_valid", 32'(instr_valid), 32'd1);
      check("t1_pc", instr_pc, 32'(4 * k));
      check("t1_instr", instr, mem_word(32'(4 * k)));
      cycle(1'b1, 1'b0, '0);
    end

    // Decoder stalled: queue fills, requests stop.
    apply_reset();
    repeat (8) cycle(1'b0, 1'b0, '0);
    check("t2_req_off", 32'(imem_req), 32'd0);
    check("t2_fetch_pc", fetch_pc, 32'd16);
    check("t2_valid", 32'(instr_valid), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("t2_order", instr_pc, 32'(4 * k));
      cycle(1'b1, 1'b0, '0);
    end
    repeat (6) cycle(1'b1, 1'b0, '0);

    // Redirect together with ack and pop.
    check("t4_pre_req", 32'(imem_req), 32'd1);
    check("t4_pre_valid", 32'(instr_valid), 32'd1);
    cycle(1'b1, 1'b1, 32'h0000_0200);
    check("t4_valid", 32'(instr_valid), 32'd0);
    check("t4_fetch_pc", fetch_pc, 32'h0000_0200);
    check("t4_req", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("t4_new_req", 32'(imem_req), 32'd1);
    check("t4_new_addr", imem_addr, 32'h0000_0200);
    repeat (4) cycle(1'b1, 1'b0, '0);

    // Wrap of fetch_pc; low redirect bits ignored.
    cycle(1'b1, 1'b1, 32'hFFFF_FFFF);
    n = 0;
    while (!(imem_req && imem_addr == 32'hFFFF_FFFC) && n < 10) begin
      cycle(1'b1, 1'b0, '0);
      n++;
    end
    check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(1'b1, 1'b0, '0);
    check("t5_wrap_addr", imem_addr, 32'h0000_0000);
    check("t5_wrap_req", 32'(imem_req), 32'd1);
    check("t5_wrap_fpc", fetch_pc, 32'h0000_0000);
    repeat (4) cycle(1'b1, 1'b0, '0);

    // Slow memory, redirect while a request is outstanding.
    apply_reset();
    lat = 3;
    cycle(1'b1, 1'b0, '0);
    check("t3_req", 32'(imem_req), 32'd1);
    cycle(1'b1, 1'b0, '0);
    cycle(1'b1, 1'b1, 32'h0000_0100);
    check("t3_fetch_pc", fetch_pc, 32'h0000_0100);
    check("t3_valid", 32'(instr_valid), 32'd0);
    check("t3_held_req", 32'(imem_req), 32'd1);
    check("t3_held_addr", imem_addr, RESET_PC);
    n = 0;
    while (imem_req && n < 10) begin
      cycle(1'b1, 1'b0, '0);
      n++;
    end
    check("t3_drop_done", 32'(imem_req), 32'd0);
    cycle(1'b1, 1'b0, '0);
    check("t3_new_req", 32'(imem_req), 32'd1);
    check("t3_new_addr", imem_addr, 32'h0000_0100);
    n = 0;
    while (!instr_valid && n < 10) begin
      cycle(1'b1, 1'b0, '0);
      n++;
    end
    check("t3_first_valid", 32'(instr_valid), 32'd1);
    check("t3_first_pc", instr_pc, 32'h0000_0100);
    repeat (4) cycle(1'b1, 1'b0, '0);

    // Reset mid-transaction with two entries queued.
    apply_reset();
    lat = 2;
    n = 0;
    while (ack_cnt < 2 && n < 30) begin
      cycle(1'b0, 1'b0, '0);
      n++;
    end
    check("t6_acks", 32'(ack_cnt), 32'd2);
    check("t6_pre_req", 32'(imem_req), 32'd1);
    check("t6_pre_valid", 32'(instr_valid), 32'd1);
    apply_reset();
    cycle(1'b1, 1'b0, '0);
    check("t6_req", 32'(imem_req), 32'd1);
    check("t6_addr", imem_addr, RESET_PC);
    repeat (8) cycle(1'b1, 1'b0, '0);

    // Randomized traffic against the program-order model.
    a0 = accepted;
    for (int i = 0; i < 1500; i++) begin
      lat = $urandom_range(0, 3);
      cycle($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom);
    end
    check("rand_progress", 32'((accepted - a0) > 100), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
